serial_char_receiver: RTL and testbench



---
 rtl/serial_rx_pkg.sv | 45 ++++
 rtl/char_fifo.sv | 67 ++++++
 rtl/serial_char_receiver.sv | 133 +++++++++++++
 tb/tb_serial_char_receiver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial character receiver.
//   char_class_t : 3-bit class attached to each received character.
//   rx_state_t   : receiver FSM state.
//   classify()   : maps a character code to its class.
package serial_rx_pkg;

   typedef enum logic [2:0] {
      PRINTABLE  = 3'd0,
      ENTER      = 3'd1,
      TAB        = 3'd2,
      BACKSPACE  = 3'd3,
      ESCAPE     = 3'd4,
      CTRL_OTHER = 3'd5
   } char_class_t;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } rx_state_t;

   localparam int unsigned CHR_CR  = 13;
   localparam int unsigned CHR_TAB = 9;
   localparam int unsigned CHR_BS  = 8;
   localparam int unsigned CHR_ESC = 27;
   localparam int unsigned CHR_DEL = 127;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   // Code is passed zero-extended so any DATA_BITS width classifies the same way.
   function automatic char_class_t classify(input int unsigned code);
      char_class_t cls;
      if (code == CHR_CR)                  cls = ENTER;
      else if (code == CHR_TAB)            cls = TAB;
      else if (code == CHR_BS)             cls = BACKSPACE;
      else if (code == CHR_ESC)            cls = ESCAPE;
      else if (code < 32 || code == CHR_DEL) cls = CTRL_OTHER;
      else                                 cls = PRINTABLE;
      return cls;
   endfunction

endpackage

// File: rtl/char_fifo.sv
// Show-ahead FIFO holding received characters.
//   clk, reset : clock and synchronous active-high reset
//   push/wdata : write request and data; ignored when full unless a pop happens too
//   pop        : read request; ignored when empty
//   rdata      : head entry (meaningful only when !empty)
//   full/empty : occupancy flags
module char_fifo #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(DEPTH));
   assign rdata = mem_q[rd_ptr_q];

   // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/serial_char_receiver.sv
// Serial character receiver: deserialises start/data/(parity)/stop frames sampled on
// bit_en, validates parity and stop, classifies the character and queues it.
//   clk, reset      : clock and synchronous active-high reset
//   bit_en, data    : sample strobe and serial line (idles high, LSB first)
//   out_valid/ready : FIFO head handshake; out_code/out_class are 0 when empty
//   parity_err      : pulse, frame dropped on parity mismatch
//   framing_err     : pulse, frame dropped on a 0 stop bit
//   overflow        : pulse, good frame dropped because the FIFO was full
//   rx_busy         : FSM is not idle
module serial_char_receiver
   import serial_rx_pkg::*;
#(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY_MODE = 0,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 bit_en,
   input  logic                 data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] out_code,
   output logic [2:0]           out_class,
   output logic                 parity_err,
   output logic                 framing_err,
   output logic                 overflow,
   output logic                 rx_busy
);

   localparam int unsigned CntW  = $clog2(DATA_BITS);
   localparam int unsigned FifoW = DATA_BITS + 3;

   rx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 par_bad_q, par_bad_d;
   logic                 commit_q, commit_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;

   char_class_t          cur_class;
   logic [FifoW-1:0]     head;
   logic                 fifo_full, fifo_empty;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      par_bad_d = par_bad_q;
      commit_d  = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      if (bit_en) begin
         unique case (state_q)
            StIdle: begin
               if (!data) begin
                  state_d   = StData;
                  cnt_d     = '0;
                  par_bad_d = 1'b0;
               end
            end
            StData: begin
               shift_d = {data, shift_q[DATA_BITS-1:1]};
               if (cnt_q == CntW'(DATA_BITS - 1)) begin
                  state_d = (PARITY_MODE != PARITY_NONE) ? StParity : StStop;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StParity: begin
               // Even: XOR of data and parity must be 0; odd: must be 1.
               par_bad_d = ((^shift_q) ^ data) != (PARITY_MODE == PARITY_ODD);
               state_d   = StStop;
            end
            StStop: begin
               state_d = StIdle;
               if (!data)          ferr_d   = 1'b1;
               else if (par_bad_q) perr_d   = 1'b1;
               else                commit_d = 1'b1;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         cnt_q     <= '0;
         par_bad_q <= 1'b0;
         commit_q  <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         par_bad_q <= par_bad_d;
         commit_q  <= commit_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
      end
   end

   // shift_q is untouched until the first data bit of the next frame, so it still holds
   // the committed code during the push cycle.
   assign cur_class = classify(32'(shift_q));

   char_fifo #(
      .WIDTH (FifoW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (commit_q),
      .wdata ({cur_class, shift_q}),
      .pop   (out_ready),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid   = !fifo_empty;
   assign out_code    = fifo_empty ? '0 : head[DATA_BITS-1:0];
   assign out_class   = fifo_empty ? 3'd0 : head[FifoW-1:DATA_BITS];
   assign parity_err  = perr_q;
   assign framing_err = ferr_q;
   assign overflow    = commit_q && fifo_full && !(out_valid && out_ready);
   assign rx_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_serial_char_receiver.sv
module tb_serial_char_receiver;
   import serial_rx_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       en0, data0, rdy0;
   logic       en1, data1, rdy1;
   logic       v0, perr0, ferr0, ovf0, busy0;
   logic       v1, perr1, ferr1, ovf1, busy1;
   logic [7:0] code0, code1;
   logic [2:0] cls0, cls1;

   int total = 0;
   int bad   = 0;

   serial_char_receiver #(
      .DATA_BITS   (8),
      .PARITY_MODE (0),
      .FIFO_DEPTH  (4)
   ) dut0 (
      .clk         (clk),
      .reset       (reset),
      .bit_en      (en0),
      .data        (data0),
      .out_valid   (v0),
      .out_ready   (rdy0),
      .out_code    (code0),
      .out_class   (cls0),
      .parity_err  (perr0),
      .framing_err (ferr0),
      .overflow    (ovf0),
      .rx_busy     (busy0)
   );

   serial_char_receiver #(
      .DATA_BITS   (8),
      .PARITY_MODE (1),
      .FIFO_DEPTH  (4)
   ) dut1 (
      .clk         (clk),
      .reset       (reset),
      .bit_en      (en1),
      .data        (data1),
      .out_valid   (v1),
      .out_ready   (rdy1),
      .out_code    (code1),
      .out_class   (cls1),
      .parity_err  (perr1),
      .framing_err (ferr1),
      .overflow    (ovf1),
      .rx_busy     (busy1)
   );

   typedef struct {
      logic [7:0] code;
      logic       stop;
      logic       exp_push;
      logic [2:0] exp_class;
   } vec_t;

   vec_t vecs [11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Waits gap idle cycles, then samples bit b with one bit_en cycle.
   task automatic drive_bit(input int which, input logic b, input int gap);
      if (which == 0) data0 = b;
      else            data1 = b;
      repeat (gap) tick();
      if (which == 0) en0 = 1'b1;
      else            en1 = 1'b1;
      tick();
      en0 = 1'b0;
      en1 = 1'b0;
   endtask

   // Returns in the cycle right after the stop-bit sample (the push/error cycle).
   task automatic send_frame(input int which, input logic [7:0] code, input logic use_par,
                             input logic par, input logic stop, input int gap);
      drive_bit(which, 1'b0, gap);
      for (int i = 0; i < 8; i++) drive_bit(which, code[i], gap);
      if (use_par) drive_bit(which, par, gap);
      drive_bit(which, stop, gap);
   endtask

   initial begin
      vecs[0]  = '{8'h41, 1'b1, 1'b1, PRINTABLE};
      vecs[1]  = '{8'h0D, 1'b1, 1'b1, ENTER};
      vecs[2]  = '{8'h09, 1'b1, 1'b1, TAB};
      vecs[3]  = '{8'h08, 1'b1, 1'b1, BACKSPACE};
      vecs[4]  = '{8'h1B, 1'b1, 1'b1, ESCAPE};
      vecs[5]  = '{8'h7F, 1'b1, 1'b1, CTRL_OTHER};
      vecs[6]  = '{8'h00, 1'b1, 1'b1, CTRL_OTHER};
      vecs[7]  = '{8'h20, 1'b1, 1'b1, PRINTABLE};
      vecs[8]  = '{8'h1F, 1'b1, 1'b1, CTRL_OTHER};
      vecs[9]  = '{8'h80, 1'b1, 1'b1, PRINTABLE};
      vecs[10] = '{8'h55, 1'b0, 1'b0, PRINTABLE};

      reset = 1'b1;
      en0 = 1'b0; data0 = 1'b1; rdy0 = 1'b0;
      en1 = 1'b0; data1 = 1'b1; rdy1 = 1'b0;
      tick();
      tick();
      chk("rst_valid0", v0, 0);
      chk("rst_code0", code0, 0);
      chk("rst_class0", cls0, 0);
      chk("rst_errs0", {perr0, ferr0, ovf0}, 0);
      chk("rst_busy0", busy0, 0);
      chk("rst_valid1", v1, 0);
      chk("rst_busy1", busy1, 0);
      reset = 1'b0;
      tick();

      // Table: one frame each, error cycle, latency, head contents, pop.
      for (int i = 0; i < 11; i++) begin
         send_frame(0, vecs[i].code, 1'b0, 1'b0, vecs[i].stop, 0);
         chk($sformatf("ferr[%0d]", i), ferr0, int'(!vecs[i].stop));
         chk($sformatf("perr[%0d]", i), perr0, 0);
         chk($sformatf("ovf[%0d]", i), ovf0, 0);
         chk($sformatf("valid_early[%0d]", i), v0, 0);
         tick();
         chk($sformatf("ferr_once[%0d]", i), ferr0, 0);
         chk($sformatf("valid[%0d]", i), v0, int'(vecs[i].exp_push));
         if (vecs[i].exp_push) begin
            chk($sformatf("code[%0d]", i), code0, int'(vecs[i].code));
            chk($sformatf("class[%0d]", i), cls0, int'(vecs[i].exp_class));
         end
         rdy0 = 1'b1;
         tick();
         rdy0 = 1'b0;
         chk($sformatf("popped[%0d]", i), v0, 0);
         chk($sformatf("empty_code[%0d]", i), code0, 0);
      end

      // Line stayed 0 after the bad stop; the next bit_en must be a fresh start bit.
      send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1, 0);
      chk("restart_ferr", ferr0, 0);
      tick();
      chk("restart_valid", v0, 1);
      chk("restart_code", code0, 'h33);
      rdy0 = 1'b1; tick(); rdy0 = 1'b0;

      // Even parity: 0x41 has two ones, so parity bit must be 0.
      send_frame(1, 8'h41, 1'b1, 1'b1, 1'b1, 0);
      chk("par_bad_perr", perr1, 1);
      chk("par_bad_ferr", ferr1, 0);
      tick();
      chk("par_bad_once", perr1, 0);
      chk("par_bad_nopush", v1, 0);
      send_frame(1, 8'h41, 1'b1, 1'b0, 1'b1, 0);
      chk("par_ok_perr", perr1, 0);
      tick();
      chk("par_ok_valid", v1, 1);
      chk("par_ok_code", code1, 'h41);
      chk("par_ok_class", cls1, PRINTABLE);
      rdy1 = 1'b1; tick(); rdy1 = 1'b0;
      // Bad parity and bad stop together: framing wins.
      send_frame(1, 8'h41, 1'b1, 1'b1, 1'b0, 0);
      chk("both_ferr", ferr1, 1);
      chk("both_perr", perr1, 0);
      data1 = 1'b1;
      tick();
      chk("both_nopush", v1, 0);
      // 0x07 has three ones: parity 1 is correct.
      send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 0);
      chk("par07_perr", perr1, 0);
      tick();
      chk("par07_code", code1, 'h07);
      chk("par07_class", cls1, CTRL_OTHER);
      rdy1 = 1'b1; tick(); rdy1 = 1'b0;
      send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 0);
      chk("par07_bad", perr1, 1);

      // Overflow: four held, fifth dropped, drain in order.
      for (int k = 0; k < 5; k++) begin
         send_frame(0, 8'h31 + 8'(k), 1'b0, 1'b0, 1'b1, 0);
         chk($sformatf("ovf_fill[%0d]", k), ovf0, int'(k == 4));
         tick();
         chk($sformatf("ovf_once[%0d]", k), ovf0, 0);
      end
      rdy0 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain_valid[%0d]", k), v0, 1);
         chk($sformatf("drain_code[%0d]", k), code0, 'h31 + k);
         tick();
      end
      rdy0 = 1'b0;
      chk("drain_empty", v0, 0);

      // Push and pop in the same cycle while full: both accepted, no overflow.
      for (int k = 0; k < 4; k++) begin
         send_frame(0, 8'h41 + 8'(k), 1'b0, 1'b0, 1'b1, 0);
         tick();
      end
      send_frame(0, 8'h45, 1'b0, 1'b0, 1'b1, 0);
      rdy0 = 1'b1;
      #1;
      chk("fullpop_ovf", ovf0, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("fullpop_code[%0d]", k), code0, 'h42 + k);
         tick();
      end
      rdy0 = 1'b0;
      chk("fullpop_empty", v0, 0);

      // bit_en every 4th cycle; reset abandons a frame after 3 data bits.
      drive_bit(0, 1'b0, 3);
      drive_bit(0, 1'b1, 3);
      drive_bit(0, 1'b0, 3);
      drive_bit(0, 1'b1, 3);
      chk("mid_busy", busy0, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_busy", busy0, 0);
      chk("rst_mid_errs", {perr0, ferr0, ovf0}, 0);
      data0 = 1'b1;
      tick();
      chk("rst_mid_errs2", {perr0, ferr0}, 0);
      send_frame(0, 8'h30, 1'b0, 1'b0, 1'b1, 3);
      chk("slow_errs", {perr0, ferr0, ovf0}, 0);
      chk("slow_early", v0, 0);
      tick();
      chk("slow_valid", v0, 1);
      chk("slow_code", code0, 'h30);
      chk("slow_class", cls0, PRINTABLE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
